// File: rtl/mrf_acc_if.sv
// mrf_acc_if: beat-in / drain-out bundle for the multi-channel term accumulator.
// Carries the input beat handshake (in_valid/in_ready, count, mode, reg_data) and the
// drain handshake (out_valid/out_ready, reg_out, out_ch, out_last) plus the sticky err flag.
// The slave modport is the accumulator's view; the master modport is the producer/consumer view.
interface mrf_acc_if #(
    parameter int WORDWIDTH = 32,
    parameter int NUM1      = 5,
    parameter int CHANNEL   = 6
);
    localparam int CW = $clog2(CHANNEL * NUM1);
    localparam int KW = $clog2(CHANNEL);

    logic                 in_valid;
    logic                 in_ready;
    logic [CW-1:0]        count;
    logic                 mode;
    logic [WORDWIDTH-1:0] reg_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [WORDWIDTH-1:0] reg_out;
    logic [KW-1:0]        out_ch;
    logic                 out_last;
    logic                 err;

    modport slave (
        input  in_valid, count, mode, reg_data, out_ready,
        output in_ready, out_valid, reg_out, out_ch, out_last, err
    );

    modport master (
        output in_valid, count, mode, reg_data, out_ready,
        input  in_ready, out_valid, reg_out, out_ch, out_last, err
    );
endinterface

// File: rtl/mrf_acc.sv
// mrf_acc: CHANNEL registers built from NUM1 terms each (overwrite or signed accumulate), drained in order.
// Latency: a register update is visible one cycle after the accepting edge; drain starts the cycle after count==CHANNEL*NUM1-1.
// Backpressure: in_ready=0 for the whole drain; drain words hold stable while out_ready=0, no bubbles between words.
// Ports: clk, rst_n (async active-low), bus (mrf_acc_if.slave: input beats, drain words, sticky err).
// Optional: define MRF_ACC_SAT_EN to saturate accumulation to the signed range instead of wrapping.
module mrf_acc #(
    parameter int WORDWIDTH = 32,
    parameter int NUM1      = 5,
    parameter int CHANNEL   = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    mrf_acc_if.slave    bus
);
    localparam int TOTAL = CHANNEL * NUM1;
    localparam int CW    = $clog2(TOTAL);
    localparam int KW    = $clog2(CHANNEL);
    localparam int WW    = WORDWIDTH;

    localparam logic [CW-1:0] LAST_CNT = CW'(TOTAL - 1);
    localparam logic [CW-1:0] NUM1_C   = CW'(NUM1);
    localparam logic [KW-1:0] LAST_K   = KW'(CHANNEL - 1);

    typedef enum logic {
        ACC   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic            rdy_q;    // holds in_ready low until the first edge after reset release
    logic            err_q;
    logic [WW-1:0]   regs_q [CHANNEL];

    logic            in_rdy;
    logic            accept;
    logic            in_range;
    logic [KW-1:0]   ch_idx;
    logic [CW-1:0]   term;
    logic            wr_en;
    logic [WW-1:0]   cur;
    logic [WW-1:0]   sum_w;
    logic [WW-1:0]   new_val;

    assign in_rdy   = (state_q == ACC) && rdy_q;
    assign accept   = bus.in_valid && in_rdy;
    assign in_range = (bus.count <= LAST_CNT);
    assign ch_idx   = KW'(bus.count / NUM1_C);
    assign term     = bus.count % NUM1_C;
    assign wr_en    = accept && in_range;
    assign cur      = regs_q[ch_idx];

`ifdef MRF_ACC_SAT_EN
    localparam logic [WW-1:0] SAT_MAX = {1'b0, {(WW-1){1'b1}}};
    localparam logic [WW-1:0] SAT_MIN = {1'b1, {(WW-1){1'b0}}};
    logic [WW:0] sum_ext;

    // One extra sign bit: overflow whenever the top two bits of the sum disagree.
    assign sum_ext = {cur[WW-1], cur} + {bus.reg_data[WW-1], bus.reg_data};
    always_comb begin
        sum_w = sum_ext[WW-1:0];
        if (sum_ext[WW] != sum_ext[WW-1]) begin
            sum_w = sum_ext[WW] ? SAT_MIN : SAT_MAX;
        end
    end
`else
    assign sum_w = cur + bus.reg_data;
`endif

    // Term 0 always starts a fresh sum, whatever the mode.
    assign new_val = ((term == '0) || !bus.mode) ? bus.reg_data : sum_w;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACC;
            k_q     <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            rdy_q   <= 1'b1;
        end
    end

    // Channel registers and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
            for (int i = 0; i < CHANNEL; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            if (accept && !in_range) begin
                err_q <= 1'b1;
            end
            if (wr_en) begin
                regs_q[ch_idx] <= new_val;
            end
        end
    end

    // Next state and outputs.
    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        bus.in_ready  = in_rdy;
        bus.out_valid = 1'b0;
        bus.reg_out   = '0;
        bus.out_ch    = k_q;
        bus.out_last  = 1'b0;
        bus.err       = err_q;
        case (state_q)
            ACC: begin
                // An out-of-range count never matches LAST_CNT, so it cannot start a drain.
                if (accept && (bus.count == LAST_CNT)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                bus.out_valid = 1'b1;
                bus.reg_out   = regs_q[k_q];
                bus.out_last  = (k_q == LAST_K);
                if (bus.out_ready) begin
                    if (k_q == LAST_K) begin
                        state_d = ACC;
                        k_d     = '0;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ACC;
                k_d     = '0;
            end
        endcase
    end
endmodule
